// File: rtl/usb_reg_bridge_pkg.sv
// Shared definitions for the USB-to-register bridge: FSM encoding and
// default parameter values.
package usb_reg_bridge_pkg;

  localparam int DEF_BYTECNT_SIZE    = 7;
  localparam int DEF_REGISTERED_READ = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR       = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_DRIVE = 2'd3
  } state_e;

endpackage

// File: rtl/usb_reg_bridge.sv
// Bridges an asynchronous MCU-style strobe bus onto single-cycle register
// read/write pulses; the read byte is presented on usb_dout while usb_isout is high.
module usb_reg_bridge
  import usb_reg_bridge_pkg::*;
#(
  parameter int pBYTECNT_SIZE    = DEF_BYTECNT_SIZE,
  parameter int pREGISTERED_READ = DEF_REGISTERED_READ,
  parameter int pADDR_WIDTH      = 8 + pBYTECNT_SIZE
) (
  input  logic                     usb_clk,
  input  logic                     reset,
  input  logic [pADDR_WIDTH-1:0]   usb_addr,
  input  logic [7:0]               usb_din,
  output logic [7:0]               usb_dout,
  output logic                     usb_isout,
  input  logic                     usb_cen_n,
  input  logic                     usb_rdn,
  input  logic                     usb_wrn,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               write_data,
  input  logic [7:0]               read_data,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     protocol_err
);

  logic [pADDR_WIDTH-1:0] addr_q;
  logic [7:0]             din_q;
  logic                   cen_n_q, rdn_q, wrn_q;
  logic                   rdn_prev_q, wrn_prev_q;
  logic [1:0]             warm_q;

  state_e                 state_q, state_d;
  logic [pADDR_WIDTH-1:0] addr_lat_q;
  logic [7:0]             wdata_q;
  logic [7:0]             dout_q;
  logic                   rd_pulse_q, wr_pulse_q;
  logic                   rd_cnt_q;
  logic                   perr_q;

  logic rd_fall, wr_fall, start_wr, start_rd, start_err, is_idle, rd_ready;

  // Input stage plus a second strobe copy for edge detection.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      din_q      <= '0;
      cen_n_q    <= 1'b1;
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      rdn_prev_q <= 1'b1;
      wrn_prev_q <= 1'b1;
      warm_q     <= 2'b00;
    end else begin
      addr_q     <= usb_addr;
      din_q      <= usb_din;
      cen_n_q    <= usb_cen_n;
      rdn_q      <= usb_rdn;
      wrn_q      <= usb_wrn;
      rdn_prev_q <= rdn_q;
      wrn_prev_q <= wrn_q;
      warm_q     <= {warm_q[0], 1'b1};
    end
  end

  // Edges only count once both strobe copies hold real post-reset samples,
  // so a strobe held low across reset release never looks like a fall.
  assign rd_fall   = warm_q[1] & rdn_prev_q & ~rdn_q;
  assign wr_fall   = warm_q[1] & wrn_prev_q & ~wrn_q;
  assign start_wr  = ~cen_n_q & wr_fall & rdn_q;
  assign start_rd  = ~cen_n_q & rd_fall & wrn_q;
  assign start_err = ~cen_n_q & (rd_fall | wr_fall) & ~rdn_q & ~wrn_q;
  assign is_idle   = (state_q == ST_IDLE);
  assign rd_ready  = (rd_cnt_q == 1'(pREGISTERED_READ));

  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          state_d = ST_WR;
        end else if (start_rd) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR: begin
        if (wrn_q || cen_n_q) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cen_n_q) begin
          state_d = ST_IDLE;
        end else if (rd_ready) begin
          state_d = ST_RD_DRIVE;
        end
      end
      ST_RD_DRIVE: begin
        if (rdn_q || cen_n_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    usb_isout = (state_q == ST_RD_DRIVE);
    reg_read  = rd_pulse_q;
    reg_write = wr_pulse_q;
  end

  // Datapath: latched address/data, pulses, read-latency counter, sticky error.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      addr_lat_q <= '0;
      wdata_q    <= '0;
      dout_q     <= '0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      rd_cnt_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rd_pulse_q <= is_idle & start_rd;
      wr_pulse_q <= is_idle & start_wr;
      if (is_idle && (start_wr || start_rd)) addr_lat_q <= addr_q;
      if (is_idle && start_wr) wdata_q <= din_q;
      if (is_idle && start_rd) begin
        rd_cnt_q <= 1'b0;
      end else if (state_q == ST_RD_WAIT && !rd_ready) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      if (state_q == ST_RD_WAIT && !cen_n_q && rd_ready) dout_q <= read_data;
      if (is_idle && start_err) perr_q <= 1'b1;
    end
  end

  assign reg_address  = addr_lat_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
  assign reg_bytecnt  = addr_lat_q[pBYTECNT_SIZE-1:0];
  assign write_data   = wdata_q;
  assign usb_dout     = dout_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed bench for usb_reg_bridge: a vector table of single transactions plus
// hand-written sequences for protocol error, chip-enable abort, reset and bursts.
module tb_usb_reg_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] usb_addr;
  logic [7:0]  usb_din;
  logic [7:0]  usb_dout;
  logic        usb_isout;
  logic        usb_cen_n, usb_rdn, usb_wrn;
  logic [7:0]  reg_address;
  logic [6:0]  reg_bytecnt;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        reg_read, reg_write, protocol_err;

  always #5 clk = ~clk;

  usb_reg_bridge dut (
    .usb_clk      (clk),
    .reset        (reset),
    .usb_addr     (usb_addr),
    .usb_din      (usb_din),
    .usb_dout     (usb_dout),
    .usb_isout    (usb_isout),
    .usb_cen_n    (usb_cen_n),
    .usb_rdn      (usb_rdn),
    .usb_wrn      (usb_wrn),
    .reg_address  (reg_address),
    .reg_bytecnt  (reg_bytecnt),
    .write_data   (write_data),
    .read_data    (read_data),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .protocol_err (protocol_err)
  );

  // Register block model with one cycle of read latency; zero otherwise so a
  // capture on the wrong cycle is visible.
  always @(posedge clk) begin
    read_data <= reg_read ? (8'h3D ^ reg_address ^ {1'b0, reg_bytecnt}) : 8'h00;
  end

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  bit isout_seen = 1'b0;
  logic [6:0] bc_log [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (reg_write) begin
      if (wr_cnt < 64) bc_log[wr_cnt] = reg_bytecnt;
      wr_cnt++;
    end
    if (reg_read) rd_cnt++;
    if (reg_read && reg_write) both_cnt++;
    if (usb_isout) isout_seen = 1'b1;
  endtask

  typedef struct {
    bit         is_rd;
    bit         cen_n;
    logic [14:0] addr;
    logic [7:0] din;
    int         hold;
    int         exp_pulses;
    logic [7:0] exp_reg;
    logic [6:0] exp_bc;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    int w0, r0, lat, base;

    vecs[0] = '{1'b0, 1'b0, 15'h0102, 8'hA5, 4, 1, 8'h02, 7'h02, 8'hA5};
    vecs[1] = '{1'b0, 1'b0, 15'h7FFF, 8'h5A, 1, 1, 8'hFF, 7'h7F, 8'h5A};
    vecs[2] = '{1'b1, 1'b0, 15'h0080, 8'h00, 3, 1, 8'h01, 7'h00, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 15'h7F81, 8'h00, 1, 1, 8'hFF, 7'h01, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 15'h0000, 8'h00, 6, 1, 8'h00, 7'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 15'h0205, 8'h00, 2, 1, 8'h04, 7'h05, 8'h3C};
    vecs[6] = '{1'b0, 1'b1, 15'h0333, 8'h77, 3, 0, 8'h04, 7'h05, 8'h00};

    reset = 1'b1; usb_addr = '0; usb_din = '0;
    usb_cen_n = 1'b1; usb_rdn = 1'b1; usb_wrn = 1'b1;
    #1;
    check("rst_isout", usb_isout, 0);
    check("rst_reg_read", reg_read, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_dout", usb_dout, 0);
    check("rst_reg_address", reg_address, 0);
    check("rst_bytecnt", reg_bytecnt, 0);
    check("rst_write_data", write_data, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 7; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      usb_addr = vecs[i].addr;
      usb_din = vecs[i].din;
      usb_cen_n = vecs[i].cen_n;
      if (!vecs[i].is_rd) begin
        usb_wrn = 1'b0;
        repeat (vecs[i].hold) tick();
        usb_wrn = 1'b1; usb_cen_n = 1'b1;
        repeat (4) tick();
        $display("vec %0d write addr=0x%0h din=0x%0h pulses=%0d", i, vecs[i].addr, vecs[i].din, wr_cnt - w0);
        check($sformatf("v%0d_wr_pulses", i), wr_cnt - w0, vecs[i].exp_pulses);
        check($sformatf("v%0d_rd_pulses", i), rd_cnt - r0, 0);
        check($sformatf("v%0d_write_data", i), write_data, vecs[i].exp_data);
      end else begin
        usb_rdn = 1'b0;
        lat = 0;
        while (!usb_isout && lat < 20) begin
          tick();
          lat++;
        end
        check($sformatf("v%0d_isout_latency", i), lat, 4);
        check($sformatf("v%0d_dout", i), usb_dout, vecs[i].exp_data);
        repeat (vecs[i].hold) tick();
        check($sformatf("v%0d_isout_held", i), usb_isout, 1);
        usb_rdn = 1'b1; usb_cen_n = 1'b1;
        tick();
        check($sformatf("v%0d_isout_before_drop", i), usb_isout, 1);
        tick();
        check($sformatf("v%0d_isout_drop", i), usb_isout, 0);
        repeat (2) tick();
        $display("vec %0d read addr=0x%0h dout=0x%0h latency=%0d", i, vecs[i].addr, usb_dout, lat);
        check($sformatf("v%0d_rd_pulses", i), rd_cnt - r0, vecs[i].exp_pulses);
        check($sformatf("v%0d_wr_pulses", i), wr_cnt - w0, 0);
      end
      check($sformatf("v%0d_reg_address", i), reg_address, vecs[i].exp_reg);
      check($sformatf("v%0d_bytecnt", i), reg_bytecnt, vecs[i].exp_bc);
    end

    // Both strobes falling together is a protocol error.
    w0 = wr_cnt; r0 = rd_cnt;
    usb_addr = 15'h0100; usb_cen_n = 1'b0; usb_rdn = 1'b0; usb_wrn = 1'b0;
    repeat (4) tick();
    check("perr_set", protocol_err, 1);
    usb_rdn = 1'b1; usb_wrn = 1'b1; usb_cen_n = 1'b1;
    repeat (3) tick();
    $display("protocol error sequence perr=%0d pulses=%0d", protocol_err, (wr_cnt - w0) + (rd_cnt - r0));
    check("perr_sticky", protocol_err, 1);
    check("perr_no_pulses", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // Chip enable withdrawn one cycle after a read starts.
    r0 = rd_cnt; isout_seen = 1'b0;
    usb_addr = 15'h0180; usb_cen_n = 1'b0; usb_rdn = 1'b0;
    tick();
    usb_cen_n = 1'b1;
    repeat (6) tick();
    usb_rdn = 1'b1;
    repeat (2) tick();
    $display("cen abort read pulses=%0d isout_seen=%0d", rd_cnt - r0, isout_seen);
    check("abort_isout_never", isout_seen, 0);
    check("abort_rd_pulses", rd_cnt - r0, 1);
    w0 = wr_cnt;
    usb_addr = 15'h0203; usb_din = 8'h99; usb_cen_n = 1'b0; usb_wrn = 1'b0;
    repeat (2) tick();
    usb_wrn = 1'b1; usb_cen_n = 1'b1;
    repeat (3) tick();
    $display("write after abort pulses=%0d data=0x%0h", wr_cnt - w0, write_data);
    check("post_abort_write", wr_cnt - w0, 1);
    check("post_abort_data", write_data, 8'h99);

    // Asynchronous reset while driving read data; strobe low across release.
    usb_addr = 15'h0080; usb_cen_n = 1'b0; usb_rdn = 1'b0;
    lat = 0;
    while (!usb_isout && lat < 20) begin
      tick();
      lat++;
    end
    check("rdrive_reached", usb_isout, 1);
    reset = 1'b1;
    #1;
    $display("reset in RD_DRIVE isout=%0d dout=0x%0h perr=%0d", usb_isout, usb_dout, protocol_err);
    check("async_rst_isout", usb_isout, 0);
    check("async_rst_dout", usb_dout, 0);
    check("async_rst_perr", protocol_err, 0);
    repeat (2) tick();
    reset = 1'b0;
    r0 = rd_cnt; isout_seen = 1'b0;
    repeat (6) tick();
    check("rel_no_read", rd_cnt - r0, 0);
    check("rel_no_isout", isout_seen, 0);
    usb_rdn = 1'b1; usb_cen_n = 1'b1;
    repeat (3) tick();

    // Back-to-back writes to bytes 0..3 of register 0.
    w0 = wr_cnt; base = wr_cnt;
    usb_cen_n = 1'b0;
    for (int b = 0; b < 4; b++) begin
      usb_addr = {8'h00, 7'(b)};
      usb_din = 8'h10 + 8'(b);
      usb_wrn = 1'b0;
      repeat (2) tick();
      usb_wrn = 1'b1;
      repeat (2) tick();
    end
    usb_cen_n = 1'b1;
    repeat (4) tick();
    $display("burst writes pulses=%0d last_data=0x%0h", wr_cnt - w0, write_data);
    check("burst_pulses", wr_cnt - w0, 4);
    for (int b = 0; b < 4; b++) begin
      if (base + b < 64) check($sformatf("burst_bc%0d", b), bc_log[base + b], b);
    end
    check("burst_last_data", write_data, 8'h13);
    check("never_both_pulses", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
